drv_segment_scan: RTL and testbench

//   Time-multiplexed scanner for a common-anode/cathode 7-segment display bank. Downstream of the
//   per-digit hex pattern array. Takes p_width 7-bit patterns and drives one shared segment bus

---
 rtl/drv_segment_pkg.sv | 20 ++
 rtl/cnt_slot.sv | 26 ++
 rtl/drv_segment_scan.sv | 137 +++++++++++++
 tb/tb_drv_segment_scan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drv_segment_pkg.sv
// Shared types and pin-polarity helper for the multiplexed 7-segment scan driver.
package drv_segment_pkg;

  typedef logic [6:0] t_sgmnt;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_ON,
    S_OFF
  } t_scan_st;

  localparam int unsigned pol_w = 16;

  // Converts an active-high vector to pin level; inv=1 yields active-low.
  function automatic logic [pol_w-1:0] apply_pol(input logic [pol_w-1:0] val, input logic inv);
    return val ^ {pol_w{inv}};
  endfunction

endpackage

// File: rtl/cnt_slot.sv
// Modulo-p_div slot counter with enable, synchronous clear and a wrap indication.
module cnt_slot #(
  parameter int unsigned p_div = 50000,
  localparam int unsigned cnt_w = $clog2(p_div)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [cnt_w-1:0] cnt,
  output logic             wrap_c
);

  assign wrap_c = en && (cnt == cnt_w'(p_div - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + cnt_w'(1);
    end
  end

endmodule

// File: rtl/drv_segment_scan.sv
// Time-multiplexed 7-segment scanner: one digit per slot with dead time, blanking
// and 16-level on-window brightness. All outputs are registered from next-state values.
module drv_segment_scan
  import drv_segment_pkg::*;
#(
  parameter int unsigned p_width   = 4,
  parameter int unsigned p_div     = 50000,
  parameter int unsigned p_dead    = 500,
  parameter int unsigned p_seg_inv = 1,
  parameter int unsigned p_an_inv  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  t_sgmnt [p_width-1:0]      i_sgmnt,
  input  logic   [p_width-1:0]      i_dp,
  input  logic   [p_width-1:0]      i_blank,
  input  logic   [3:0]              i_bright,
  output logic   [6:0]              o_seg,
  output logic                      o_dp,
  output logic   [p_width-1:0]      o_an,
  output logic                      o_frame
);

  localparam int unsigned slot_step = (p_div - p_dead) / 16;
  localparam int unsigned cnt_w     = $clog2(p_div);
  localparam int unsigned win_w     = cnt_w + 1;
  localparam int unsigned idx_w     = (p_width > 1) ? $clog2(p_width) : 1;
  localparam logic        seg_inv   = (p_seg_inv != 0);
  localparam logic        an_inv    = (p_an_inv != 0);
  localparam logic [idx_w-1:0] last_idx = idx_w'(p_width - 1);

  t_scan_st           st, st_nx;
  logic [cnt_w-1:0]   cnt;
  logic               wrap_c;
  logic               cnt_en;
  logic [idx_w-1:0]   idx, idx_nx;
  t_sgmnt             pat, pat_nx;
  logic               dp_l, dp_nx;
  logic               blank_l, blank_nx;
  logic [3:0]         bright_l, bright_nx;
  logic               slot_start;
  logic [win_w-1:0]   win_m1;
  logic [p_width-1:0] an_on;
  t_sgmnt             seg_on;
  logic               dp_on;
  logic               frame_nx;

  assign cnt_en = i_en && (st != S_IDLE);

  cnt_slot #(
    .p_div (p_div)
  ) u_cnt (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (cnt_en),
    .clr    (!cnt_en),
    .cnt    (cnt),
    .wrap_c (wrap_c)
  );

  // Slot inputs are sampled once at cnt==0; the muxed view lets decisions at cnt==0 see them.
  assign slot_start = cnt_en && (cnt == '0);
  assign pat_nx     = slot_start ? i_sgmnt[idx]  : pat;
  assign dp_nx      = slot_start ? i_dp[idx]     : dp_l;
  assign blank_nx   = slot_start ? i_blank[idx]  : blank_l;
  assign bright_nx  = slot_start ? i_bright      : bright_l;

  assign win_m1 = win_w'(p_dead)
                + (win_w'(bright_nx) + win_w'(1)) * win_w'(slot_step)
                - win_w'(1);

  assign frame_nx = cnt_en && (cnt == cnt_w'(p_div - 2)) && (idx == last_idx);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st <= S_IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    idx_nx = idx;
    an_on  = '0;
    seg_on = '0;
    dp_on  = 1'b0;
    if (!i_en) begin
      st_nx  = S_IDLE;
      idx_nx = '0;
    end else begin
      case (st)
        S_IDLE: st_nx = S_DEAD;
        S_DEAD: if (cnt == cnt_w'(p_dead - 1)) st_nx = blank_nx ? S_OFF : S_ON;
        // Full-brightness windows that reach p_div end on the wrap itself.
        S_ON: begin
          if (wrap_c) st_nx = S_DEAD;
          else if (win_w'(cnt) == win_m1) st_nx = S_OFF;
        end
        S_OFF: if (wrap_c) st_nx = S_DEAD;
        default: st_nx = S_IDLE;
      endcase
      if (wrap_c) idx_nx = (idx == last_idx) ? '0 : idx + idx_w'(1);
    end
    if (st_nx == S_ON) an_on[idx_nx] = 1'b1;
    if (st_nx != S_IDLE) begin
      seg_on = pat_nx;
      dp_on  = dp_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx      <= '0;
      pat      <= '0;
      dp_l     <= 1'b0;
      blank_l  <= 1'b0;
      bright_l <= '0;
      o_seg    <= 7'(apply_pol('0, seg_inv));
      o_dp     <= 1'(apply_pol('0, seg_inv));
      o_an     <= p_width'(apply_pol('0, an_inv));
      o_frame  <= 1'b0;
    end else begin
      idx      <= idx_nx;
      pat      <= pat_nx;
      dp_l     <= dp_nx;
      blank_l  <= blank_nx;
      bright_l <= bright_nx;
      o_seg    <= 7'(apply_pol(pol_w'(seg_on), seg_inv));
      o_dp     <= 1'(apply_pol(pol_w'(dp_on), seg_inv));
      o_an     <= p_width'(apply_pol(pol_w'(an_on), an_inv));
      o_frame  <= frame_nx;
    end
  end

endmodule

// File: tb/tb_drv_segment_scan.sv
// Directed bench for drv_segment_scan with p_width=4, p_div=20, p_dead=4, active-low pins.
module tb_drv_segment_scan;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3:0][6:0]  sgmnt;
  logic [3:0]       dp;
  logic [3:0]       blank;
  logic [3:0]       bright;
  logic [6:0]       seg;
  logic             dp_o;
  logic [3:0]       an;
  logic             frame;

  int n_chk;
  int n_fail;
  int cyc;

  int on_cnt[4];
  int first_on[4];
  int n_1011;
  int frame_cnt;
  int frame_first;
  int frame_last;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic       chk_seg;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } vec_t;

  vec_t vecs[17];

  drv_segment_scan #(
    .p_width   (4),
    .p_div     (20),
    .p_dead    (4),
    .p_seg_inv (1),
    .p_an_inv  (1)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_sgmnt  (sgmnt),
    .i_dp     (dp),
    .i_blank  (blank),
    .i_bright (bright),
    .o_seg    (seg),
    .o_dp     (dp_o),
    .o_an     (an),
    .o_frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; sample on the falling edge and check the single-anode rule.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("one_anode", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    cyc = 0;
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 4; d++) begin
      on_cnt[d]   = 0;
      first_on[d] = -1;
    end
    n_1011      = 0;
    frame_cnt   = 0;
    frame_first = -1;
    frame_last  = -1;
  endtask

  task automatic scan(input int n);
    for (int c = 0; c < n; c++) begin
      for (int d = 0; d < 4; d++) begin
        if (an[d] == 1'b0) begin
          on_cnt[d]++;
          if (first_on[d] < 0) first_on[d] = cyc;
        end
      end
      if (an == 4'b1011) n_1011++;
      if (frame) begin
        frame_cnt++;
        if (frame_first < 0) frame_first = cyc;
        frame_last = cyc;
      end
      step();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    sgmnt  = {7'h7F, 7'h06, 7'h5B, 7'h3F};
    dp     = 4'b0001;
    blank  = 4'b0000;
    bright = 4'd15;

    // cycle, an, chk_seg, seg (pin level), dp (pin level), frame
    vecs[0]  = '{0,  4'hF, 1'b0, 7'h7F, 1'b1, 1'b0};
    vecs[1]  = '{1,  4'hF, 1'b1, 7'h40, 1'b0, 1'b0};
    vecs[2]  = '{3,  4'hF, 1'b1, 7'h40, 1'b0, 1'b0};
    vecs[3]  = '{4,  4'hE, 1'b1, 7'h40, 1'b0, 1'b0};
    vecs[4]  = '{19, 4'hE, 1'b1, 7'h40, 1'b0, 1'b0};
    vecs[5]  = '{20, 4'hF, 1'b1, 7'h40, 1'b0, 1'b0};
    vecs[6]  = '{21, 4'hF, 1'b1, 7'h24, 1'b1, 1'b0};
    vecs[7]  = '{24, 4'hD, 1'b1, 7'h24, 1'b1, 1'b0};
    vecs[8]  = '{39, 4'hD, 1'b1, 7'h24, 1'b1, 1'b0};
    vecs[9]  = '{40, 4'hF, 1'b1, 7'h24, 1'b1, 1'b0};
    vecs[10] = '{44, 4'hB, 1'b1, 7'h79, 1'b1, 1'b0};
    vecs[11] = '{64, 4'h7, 1'b1, 7'h00, 1'b1, 1'b0};
    vecs[12] = '{78, 4'h7, 1'b1, 7'h00, 1'b1, 1'b0};
    vecs[13] = '{79, 4'h7, 1'b1, 7'h00, 1'b1, 1'b1};
    vecs[14] = '{80, 4'hF, 1'b1, 7'h00, 1'b1, 1'b0};
    vecs[15] = '{81, 4'hF, 1'b1, 7'h40, 1'b0, 1'b0};
    vecs[16] = '{84, 4'hE, 1'b1, 7'h40, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'h1);
    check("rst_frame", 32'(frame), 32'h0);

    // Full-brightness scan of all four digits
    rst_n = 1'b1;
    step();
    cyc = 0;
    for (int i = 0; i < 17; i++) begin
      run_to(vecs[i].cyc);
      check("t1_an", 32'(an), 32'(vecs[i].an));
      check("t1_frame", 32'(frame), 32'(vecs[i].frame));
      if (vecs[i].chk_seg) begin
        check("t1_seg", 32'(seg), 32'(vecs[i].seg));
        check("t1_dp", 32'(dp_o), 32'(vecs[i].dp));
      end
    end

    // Minimum and mid brightness windows
    bright = 4'd0;
    restart();
    clear_stats();
    scan(80);
    for (int d = 0; d < 4; d++) begin
      check("t2_b0_on", 32'(on_cnt[d]), 32'd1);
      check("t2_b0_first", 32'(first_on[d]), 32'(20 * d + 4));
    end
    bright = 4'd7;
    restart();
    clear_stats();
    scan(80);
    for (int d = 0; d < 4; d++) begin
      check("t2_b7_on", 32'(on_cnt[d]), 32'd8);
      check("t2_b7_first", 32'(first_on[d]), 32'(20 * d + 4));
    end

    // Blanked digit 2 over two frames
    bright = 4'd15;
    blank  = 4'b0100;
    restart();
    clear_stats();
    scan(160);
    check("t3_no_1011", 32'(n_1011), 32'd0);
    check("t3_d2_on", 32'(on_cnt[2]), 32'd0);
    check("t3_d0_on", 32'(on_cnt[0]), 32'd32);
    check("t3_d3_on", 32'(on_cnt[3]), 32'd32);
    check("t3_frames", 32'(frame_cnt), 32'd2);
    check("t3_frame_first", 32'(frame_first), 32'd79);
    check("t3_frame_last", 32'(frame_last), 32'd159);

    // Brightness change mid-slot of digit 1 takes effect at digit 2
    blank  = 4'b0000;
    bright = 4'd0;
    restart();
    clear_stats();
    scan(30);
    bright = 4'd15;
    scan(50);
    check("t4_d0_on", 32'(on_cnt[0]), 32'd1);
    check("t4_d1_on", 32'(on_cnt[1]), 32'd1);
    check("t4_d2_on", 32'(on_cnt[2]), 32'd16);
    check("t4_d3_on", 32'(on_cnt[3]), 32'd16);
    check("t4_d2_first", 32'(first_on[2]), 32'd44);

    // Enable dropped during digit 2 on-window, then re-enabled
    restart();
    run_to(50);
    check("t5_pre_an", 32'(an), 32'hB);
    en = 1'b0;
    step();
    check("t5_idle_an", 32'(an), 32'hF);
    check("t5_idle_seg", 32'(seg), 32'h7F);
    check("t5_idle_dp", 32'(dp_o), 32'h1);
    check("t5_idle_frame", 32'(frame), 32'h0);
    repeat (3) step();
    check("t5_hold_an", 32'(an), 32'hF);
    check("t5_hold_seg", 32'(seg), 32'h7F);
    en = 1'b1;
    step();
    cyc = 0;
    run_to(3);
    check("t5_dead_an", 32'(an), 32'hF);
    step();
    check("t5_d0_an", 32'(an), 32'hE);
    run_to(21);
    check("t5_d1_seg", 32'(seg), 32'h24);

    // Asynchronous reset pulse in the middle of a slot
    restart();
    run_to(25);
    check("t6_pre_an", 32'(an), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_an", 32'(an), 32'hF);
    check("t6_rst_seg", 32'(seg), 32'h7F);
    check("t6_rst_dp", 32'(dp_o), 32'h1);
    check("t6_rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    check("t6_hold_an", 32'(an), 32'hF);
    rst_n = 1'b1;
    step();
    cyc = 0;
    run_to(3);
    check("t6_dead_an", 32'(an), 32'hF);
    step();
    check("t6_d0_an", 32'(an), 32'hE);
    check("t6_d0_seg", 32'(seg), 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
